// File: rtl/frame_writer.sv
// Raster pixel stream to display-buffer write converter.
// Locks onto in_sof and emits {y,x}-addressed writes, with frame_done and resync pulses.
module frame_writer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int PIXEL_WIDTH = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_data,
    input  logic                   in_sof,
    input  logic                   stall,
    output logic                   wr_en,
    output logic [19:0]            wr_address,
    output logic [PIXEL_WIDTH-1:0] wr_data,
    output logic                   frame_done,
    output logic                   resync,
    output logic                   busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t                   state_r;
    state_t                   state_s;
    logic [9:0]               x_r;
    logic [9:0]               y_r;
    logic [9:0]               x_s;
    logic [9:0]               y_s;
    logic [9:0]               wx_s;
    logic [9:0]               wy_s;
    logic                     accept_s;
    logic                     write_s;
    logic                     done_s;
    logic                     resync_s;
    logic                     last_x_s;
    logic                     last_y_s;
    logic                     wr_en_r;
    logic [19:0]              wr_address_r;
    logic [PIXEL_WIDTH-1:0]   wr_data_r;
    logic                     frame_done_r;
    logic                     resync_r;
    logic                     busy_r;

    // Back-pressure comes only from the buffer write port.
    assign in_ready = !stall;
    assign accept_s = in_valid && !stall;

    // Write position selection, counter advance and next-state decode.
    always_comb begin
        state_s  = state_r;
        x_s      = x_r;
        y_s      = y_r;
        wx_s     = x_r;
        wy_s     = y_r;
        write_s  = 1'b0;
        done_s   = 1'b0;
        resync_s = 1'b0;
        if (accept_s) begin
            case (state_r)
                IDLE: begin
                    // Pixels before a start-of-frame are consumed and dropped.
                    if (in_sof) begin
                        write_s = 1'b1;
                        wx_s    = 10'd0;
                        wy_s    = 10'd0;
                    end else begin
                        write_s = 1'b0;
                    end
                end
                WRITE: begin
                    write_s = 1'b1;
                    if (in_sof) begin
                        resync_s = 1'b1;
                        wx_s     = 10'd0;
                        wy_s     = 10'd0;
                    end else begin
                        wx_s = x_r;
                        wy_s = y_r;
                    end
                end
                default: begin
                    write_s = 1'b0;
                    state_s = IDLE;
                end
            endcase
        end else begin
            write_s = 1'b0;
        end

        last_x_s = (wx_s == X_LAST);
        last_y_s = (wy_s == Y_LAST);

        if (write_s) begin
            if (last_x_s) begin
                x_s = 10'd0;
                if (last_y_s) begin
                    y_s     = 10'd0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    y_s     = wy_s + 10'd1;
                    state_s = WRITE;
                end
            end else begin
                x_s     = wx_s + 10'd1;
                y_s     = wy_s;
                state_s = WRITE;
            end
        end else begin
            x_s = x_r;
            y_s = y_r;
        end
    end

    // State, position counters and registered write-port outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            x_r          <= 10'd0;
            y_r          <= 10'd0;
            wr_en_r      <= 1'b0;
            wr_address_r <= 20'd0;
            wr_data_r    <= {PIXEL_WIDTH{1'b0}};
            frame_done_r <= 1'b0;
            resync_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            x_r          <= x_s;
            y_r          <= y_s;
            wr_en_r      <= write_s;
            frame_done_r <= done_s;
            resync_r     <= resync_s;
            busy_r       <= (state_s == WRITE);
            if (write_s) begin
                wr_address_r <= {wy_s, wx_s};
                wr_data_r    <= in_data;
            end else begin
                wr_address_r <= wr_address_r;
                wr_data_r    <= wr_data_r;
            end
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_address = wr_address_r;
    assign wr_data    = wr_data_r;
    assign frame_done = frame_done_r;
    assign resync     = resync_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: a 4x3 instance checked against a pixel-index frame model,
// plus a 1x1 instance for the single-pixel frame corner case.
module tb_frame_writer;

    localparam int H = 4;
    localparam int V = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = 24'h0;
    logic        in_sof = 1'b0;
    logic        stall = 1'b0;
    logic        wr_en;
    logic [19:0] wr_address;
    logic [23:0] wr_data;
    logic        frame_done;
    logic        resync;
    logic        busy;

    logic        v1 = 1'b0;
    logic        rdy1;
    logic [23:0] d1 = 24'h0;
    logic        s1 = 1'b0;
    logic        we1;
    logic [19:0] addr1;
    logic [23:0] data1;
    logic        done1;
    logic        rs1;
    logic        busy1;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: frame position kept as a linear pixel index
    bit          m_in_frame = 1'b0;
    int          m_idx = 0;
    logic        e_we, e_done, e_rs, e_busy;
    logic [19:0] e_addr;
    logic [23:0] e_data;
    logic        rdy_seen;
    logic [67:0] obs, exp_v;

    frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIXEL_WIDTH(24)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .stall(stall), .wr_en(wr_en),
        .wr_address(wr_address), .wr_data(wr_data), .frame_done(frame_done),
        .resync(resync), .busy(busy)
    );

    frame_writer #(.H_ACTIVE(1), .V_ACTIVE(1), .PIXEL_WIDTH(24)) dut1 (
        .clock(clock), .reset(reset), .in_valid(v1), .in_ready(rdy1),
        .in_data(d1), .in_sof(s1), .stall(1'b0), .wr_en(we1),
        .wr_address(addr1), .wr_data(data1), .frame_done(done1),
        .resync(rs1), .busy(busy1)
    );

    always #5 clock = ~clock;

    task automatic model_step(input logic v, input logic s, input logic st, input logic [23:0] d);
        e_we = 1'b0; e_done = 1'b0; e_rs = 1'b0; e_addr = 20'h0; e_data = 24'h0;
        if (v && !st) begin
            if (s) begin
                if (m_in_frame) e_rs = 1'b1;
                m_in_frame = 1'b1;
                m_idx = 0;
            end
            if (m_in_frame) begin
                e_we   = 1'b1;
                e_addr = 20'(((m_idx / H) * 1024) + (m_idx % H));
                e_data = d;
                if (m_idx == H * V - 1) begin
                    e_done = 1'b1;
                    m_in_frame = 1'b0;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        e_busy = m_in_frame;
    endtask

    // drives one cycle of stimulus starting just after a rising edge
    task automatic drive(input logic v, input logic s, input logic st, input logic [23:0] d);
        in_valid = v; in_sof = s; stall = st; in_data = d;
        #1 rdy_seen = in_ready;
        model_step(v, s, st, d);
        @(posedge clock); #1;
        obs   = {wr_en, frame_done, resync, busy, e_we ? {wr_address, wr_data} : 44'h0};
        exp_v = {e_we, e_done, e_rs, e_busy, e_we ? {e_addr, e_data} : 44'h0};
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({wr_en, wr_address, wr_data, frame_done, resync, busy} !== 48'h0) begin
            n_fail++; $display("FAIL reset_outputs got %h exp 0", {wr_en, wr_address, wr_data, frame_done, resync, busy});
        end
        stall = 1'b1; #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_stall got %b exp 0", in_ready); end
        stall = 1'b0; #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        @(posedge clock); #1 reset = 1'b0;
    endtask

    task automatic test_frame();
        for (int i = 0; i < H * V + 1; i++) begin
            drive(i < H * V, i == 0, 1'b0, 24'($urandom));
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL frame[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_drop_before_sof();
        for (int i = 0; i < 3 + H * V; i++) begin
            drive(1'b1, i == 3, 1'b0, (i < 3) ? 24'hAAAAAA : 24'($urandom));
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL drop[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_resync();
        for (int i = 0; i < 6 + H * V + 1; i++) begin
            drive(i < 6 + H * V, (i == 0) || (i == 6), 1'b0, 24'($urandom));
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL resync[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2 * H * V + 2; i++) begin
            drive(1'b1, i == 0, i[0], 24'($urandom));
            n_tests++;
            if (rdy_seen !== !i[0]) begin n_fail++; $display("FAIL stall_ready[%0d] got %b exp %b", i, rdy_seen, !i[0]); end
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL stall[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 0, 1'b0, 24'($urandom));
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL prereset[%0d] got %h exp %h", i, obs, exp_v); end
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({wr_en, wr_address, wr_data, frame_done, resync, busy} !== 48'h0) begin
            n_fail++; $display("FAIL async_reset got %h exp 0", {wr_en, wr_address, wr_data, frame_done, resync, busy});
        end
        @(posedge clock); #1 reset = 1'b0;
        m_in_frame = 1'b0; m_idx = 0;
        for (int i = 0; i < 3 + H * V; i++) begin
            drive(1'b1, i == 3, 1'b0, 24'($urandom));
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL postreset[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0, 24'($urandom));
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL random[%0d] got %h exp %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_one_pixel();
        logic [23:0] d;
        for (int i = 0; i < 3; i++) begin
            d = (i == 0) ? 24'h123456 : 24'($urandom);
            v1 = 1'b1; s1 = (i != 1); d1 = d;
            @(posedge clock); #1;
            v1 = 1'b0; s1 = 1'b0;
            n_tests++;
            if (i == 1) begin
                if ({we1, done1, rs1, busy1} !== 4'b0000) begin
                    n_fail++; $display("FAIL one_pixel_drop got %b exp 0000", {we1, done1, rs1, busy1});
                end
            end else begin
                if ({we1, done1, rs1, busy1, addr1, data1} !== {4'b1100, 20'h0, d}) begin
                    n_fail++; $display("FAIL one_pixel[%0d] got %b %h %h exp 1100 00000 %h",
                                       i, {we1, done1, rs1, busy1}, addr1, data1, d);
                end
            end
        end
        @(posedge clock); #1;
        n_tests++;
        if ({we1, done1, busy1} !== 3'b000) begin
            n_fail++; $display("FAIL one_pixel_idle got %b exp 000", {we1, done1, busy1});
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_drop_before_sof();
        test_resync();
        test_stall();
        test_async_reset();
        test_random();
        test_one_pixel();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
